// File: rtl/regfiletmp_retire.sv
// In-order retire controller for the 32-entry temporary register file.
// Reads the head entry, commits it to the architectural file or store path, clears it and advances.
module regfiletmp_retire #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          Alloc,
    input  logic          Flush,
    output logic [AW-1:0] Rd_Addr,
    input  logic [72:0]   Data_out,
    output logic          Clr_entry,
    output logic [AW-1:0] Clr_addr,
    output logic          Arch_we,
    output logic [4:0]    Arch_waddr,
    output logic [31:0]   Arch_wdata,
    output logic          Store_commit,
    output logic [31:0]   Commit_pc,
    output logic          Full,
    output logic          Empty,
    output logic          Halted
);

    typedef enum logic {RUN, HALT} state_t;

    localparam logic [1:0] TYPE_ALU   = 2'b00;
    localparam logic [1:0] TYPE_STORE = 2'b01;
    localparam logic [1:0] TYPE_HALT  = 2'b11;
    localparam logic [AW:0] COUNT_FULL = (AW+1)'(DEPTH);

    logic [AW-1:0] head, tail, head_nxt, tail_nxt;
    logic [AW:0]   count, count_nxt;
    state_t        state, state_nxt;
    logic          retire, alloc_ok;

    logic [31:0] e_data, e_pc;
    logic [4:0]  e_rd;
    logic [1:0]  e_type;

    assign e_data  = Data_out[72:41];
    assign e_pc    = Data_out[40:9];
    assign e_rd    = Data_out[8:4];
    assign e_type  = Data_out[3:2];
    assign Rd_Addr = head;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        head_nxt  = head;
        tail_nxt  = tail;
        count_nxt = count;
        state_nxt = state;
        retire    = (state == RUN) && (count != '0) && Data_out[0] && Data_out[1];
        alloc_ok  = Alloc && (count != COUNT_FULL);

        // Flush wins over both retire and Alloc; the dropped Alloc never reaches tail.
        if (Flush) begin
            head_nxt  = tail;
            count_nxt = '0;
            state_nxt = RUN;
        end else begin
            if (retire) begin
                head_nxt = head + AW'(1);
                if (e_type == TYPE_HALT)
                    state_nxt = HALT;
            end
            if (alloc_ok)
                tail_nxt = tail + AW'(1);
            count_nxt = count + (AW+1)'(alloc_ok) - (AW+1)'(retire);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            state        <= RUN;
            Clr_entry    <= 1'b0;
            Clr_addr     <= '0;
            Arch_we      <= 1'b0;
            Arch_waddr   <= '0;
            Arch_wdata   <= '0;
            Store_commit <= 1'b0;
            Commit_pc    <= '0;
            Full         <= 1'b0;
            Empty        <= 1'b1;
            Halted       <= 1'b0;
        end else begin
            head   <= head_nxt;
            tail   <= tail_nxt;
            count  <= count_nxt;
            state  <= state_nxt;
            Full   <= (count_nxt == COUNT_FULL);
            Empty  <= (count_nxt == '0);
            Halted <= (state_nxt == HALT);

            Clr_entry    <= 1'b0;
            Arch_we      <= 1'b0;
            Store_commit <= 1'b0;
            if (retire && !Flush) begin
                Clr_entry <= 1'b1;
                Clr_addr  <= head;
                Commit_pc <= e_pc;
                case (e_type)
                    TYPE_ALU: begin
                        Arch_we    <= (e_rd != 5'd0);
                        Arch_waddr <= e_rd;
                        Arch_wdata <= e_data;
                    end
                    TYPE_STORE: Store_commit <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_regfiletmp_retire.sv
// Bench for regfiletmp_retire: directed scenarios then random traffic against a queue-style model
// that also plays the role of regfiletmp storage behind Rd_Addr.
module tb_regfiletmp_retire;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [1:0]  typ;
        logic        sv;
        logic        v;
    } entry_t;

    logic        clock = 1'b0;
    logic        reset, Alloc, Flush;
    logic [4:0]  Rd_Addr, Clr_addr, Arch_waddr;
    logic [72:0] Data_out;
    logic        Clr_entry, Arch_we, Store_commit, Full, Empty, Halted;
    logic [31:0] Arch_wdata, Commit_pc;

    entry_t mem [32];
    assign Data_out = mem[Rd_Addr];

    regfiletmp_retire #(.DEPTH(32), .AW(5)) dut (
        .clock(clock), .reset(reset), .Alloc(Alloc), .Flush(Flush),
        .Rd_Addr(Rd_Addr), .Data_out(Data_out),
        .Clr_entry(Clr_entry), .Clr_addr(Clr_addr),
        .Arch_we(Arch_we), .Arch_waddr(Arch_waddr), .Arch_wdata(Arch_wdata),
        .Store_commit(Store_commit), .Commit_pc(Commit_pc),
        .Full(Full), .Empty(Empty), .Halted(Halted)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Model: occupancy and pointers as plain integers, plus the strobes expected after the edge.
    int          m_head, m_tail, m_count;
    bit          m_halt;
    bit          e_clr, e_we, e_st;
    logic [4:0]  e_clr_addr, e_waddr;
    logic [31:0] e_wdata, e_pc;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("rd_addr", 32'(Rd_Addr), 32'(m_head));
        chk("full", 32'(Full), 32'(m_count == 32));
        chk("empty", 32'(Empty), 32'(m_count == 0));
        chk("halted", 32'(Halted), 32'(m_halt));
        chk("clr_entry", 32'(Clr_entry), 32'(e_clr));
        chk("arch_we", 32'(Arch_we), 32'(e_we));
        chk("store_commit", 32'(Store_commit), 32'(e_st));
        if (e_clr) begin
            chk("clr_addr", 32'(Clr_addr), 32'(e_clr_addr));
            chk("commit_pc", Commit_pc, e_pc);
        end
        if (e_we) begin
            chk("arch_waddr", 32'(Arch_waddr), 32'(e_waddr));
            chk("arch_wdata", Arch_wdata, e_wdata);
        end
    endtask

    function automatic entry_t mk(logic [1:0] typ, logic [4:0] rd, logic [31:0] data,
                                  logic [31:0] pc, logic sv);
        entry_t e;
        e.data = data; e.pc = pc; e.rd = rd; e.typ = typ; e.sv = sv; e.v = 1'b1;
        return e;
    endfunction

    task automatic do_reset(int cycles);
        reset = 1'b1; Alloc = 1'b0; Flush = 1'b0;
        repeat (cycles) @(posedge clock);
        #1;
        reset = 1'b0;
        m_head = 0; m_tail = 0; m_count = 0; m_halt = 1'b0;
        e_clr = 1'b0; e_we = 1'b0; e_st = 1'b0;
        check_all();
    endtask

    // One clock: optional Alloc writing ent at tail, optional Flush; model predicts the result.
    task automatic step(bit alloc, bit flush, entry_t ent);
        int     ret_idx;
        int     c0;
        entry_t h;
        ret_idx = -1;
        c0 = m_count;
        if (alloc && !flush && m_count < 32) mem[m_tail] = ent;
        Alloc = alloc; Flush = flush;
        h = mem[m_head];
        e_clr = 1'b0; e_we = 1'b0; e_st = 1'b0;
        if (flush) begin
            m_head = m_tail; m_count = 0; m_halt = 1'b0;
        end else begin
            if (!m_halt && m_count > 0 && h.v && h.sv) begin
                ret_idx    = m_head;
                e_clr      = 1'b1;
                e_clr_addr = 5'(m_head);
                e_pc       = h.pc;
                case (h.typ)
                    2'd0: if (h.rd != 5'd0) begin e_we = 1'b1; e_waddr = h.rd; e_wdata = h.data; end
                    2'd1: e_st = 1'b1;
                    2'd3: m_halt = 1'b1;
                    default: ;
                endcase
                m_head = (m_head + 1) % 32;
                m_count--;
            end
            if (alloc && c0 < 32) begin
                m_tail = (m_tail + 1) % 32;
                m_count++;
            end
        end
        @(posedge clock);
        #1;
        Alloc = 1'b0; Flush = 1'b0;
        if (ret_idx >= 0) mem[ret_idx].v = 1'b0;
        check_all();
    endtask

    initial begin
        entry_t ent;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        reset = 1'b1; Alloc = 1'b0; Flush = 1'b0;
        do_reset(2);

        // ALU retire into r7
        step(1'b1, 1'b0, mk(2'd0, 5'd7, 32'hDEADBEEF, 32'h100, 1'b1));
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);

        // Head not speculatively valid while the next entry is ready
        step(1'b1, 1'b0, mk(2'd2, 5'd1, 32'h0, 32'h200, 1'b0));
        step(1'b1, 1'b0, mk(2'd2, 5'd2, 32'h0, 32'h204, 1'b1));
        repeat (5) step(1'b0, 1'b0, '0);
        mem[1].sv = 1'b1;
        repeat (3) step(1'b0, 1'b0, '0);

        // Fill to full, one extra Alloc, then drain across the wrap with Alloc in the last 8
        for (int i = 0; i < 33; i++)
            step(1'b1, 1'b0, mk(2'd2, 5'd0, 32'(i), 32'h300 + 32'(4 * i), 1'b0));
        for (int i = 0; i < 32; i++) mem[i].sv = 1'b1;
        for (int i = 0; i < 32; i++)
            step(i >= 24, 1'b0, mk(2'd2, 5'd0, 32'h0, 32'h1000 + 32'(i), 1'b0));
        chk("count_after_drain", 32'(m_count), 32'd8);
        step(1'b0, 1'b1, '0);

        // Store, rd0 ALU, halt, then a ready ALU that must wait for the flush
        step(1'b1, 1'b0, mk(2'd1, 5'd3, 32'hAAAA, 32'h400, 1'b1));
        step(1'b1, 1'b0, mk(2'd0, 5'd0, 32'hBBBB, 32'h404, 1'b1));
        step(1'b1, 1'b0, mk(2'd3, 5'd0, 32'h0, 32'h408, 1'b1));
        step(1'b1, 1'b0, mk(2'd0, 5'd5, 32'hCCCC, 32'h40C, 1'b1));
        repeat (4) step(1'b0, 1'b0, '0);
        step(1'b1, 1'b1, mk(2'd0, 5'd6, 32'hDDDD, 32'h500, 1'b1));
        step(1'b0, 1'b0, '0);
        step(1'b1, 1'b0, mk(2'd0, 5'd9, 32'h1234, 32'h600, 1'b1));
        step(1'b0, 1'b0, '0);

        // Reset while the head is ready: the pending retire is dropped
        step(1'b1, 1'b0, mk(2'd0, 5'd4, 32'h5555, 32'h700, 1'b1));
        do_reset(1);

        // Random traffic
        for (int n = 0; n < 500; n++) begin
            int r;
            if ($urandom_range(7) == 0) mem[$urandom_range(31)].sv = 1'b1;
            r = int'($urandom_range(15));
            ent = mk(r < 10 ? 2'd0 : r < 13 ? 2'd1 : r < 15 ? 2'd2 : 2'd3,
                     5'($urandom), $urandom, $urandom, 1'($urandom_range(1)));
            step($urandom_range(3) != 0, $urandom_range(39) == 0, ent);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfiletmp_retire.md
# regfiletmp_retire

In-order retire controller for the 32-entry temporary register file: the reading end of the entry protocol that dispatch writes with New_entry/Update_entry. Tracks head/tail pointers and occupancy, reads the head entry, and when its result is ready commits it to the architectural register file or store path. It then clears the entry and advances the head. Sits between regfiletmp and the architectural register file / store queue.

## Interface
- DEPTH, 32, entries in regfiletmp (power of two)
- AW, 5, log2(DEPTH)
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- Alloc  in  1  dispatch allocated an entry at tail this cycle (mirrors New_entry)
- Flush  in  1  discard all in-flight entries
- Rd_Addr  out  AW  head pointer, drives regfiletmp read port (combinational from head register)
- Data_out  in  73  entry at Rd_Addr: [72:41] spec_data, [40:9] PC, [8:4] rd_reg, [3:2] Inst_type, [1] spec_valid, [0] valid
- Clr_entry  out  1  pulse: clear valid of entry Clr_addr
- Clr_addr  out  AW  entry being retired
- Arch_we  out  1  architectural register write strobe
- Arch_waddr  out  5  destination register
- Arch_wdata  out  32  result data
- Store_commit  out  1  pulse: release store at Commit_pc
- Commit_pc  out  32  PC of the instruction retired this cycle
- Full  out  1  Count == DEPTH
- Empty  out  1  Count == 0
- Halted  out  1  halt instruction retired; retirement stopped

## Operation
- State: head (AW), tail (AW), Count (AW+1, 0..DEPTH), FSM {RUN, HALT}.
- Ready condition: RUN and Count != 0 and Data_out[0] and Data_out[1].
- On ready, by Inst_type:
  - 00 ALU: Arch_we=1, Arch_waddr=rd_reg, Arch_wdata=spec_data; rd_reg 0 gives Arch_we=0 (still retires).
  - 01 store: Store_commit=1.
  - 10 branch: no write.
  - 11 halt: no write; FSM -> HALT.
- Every retire: Clr_entry=1, Clr_addr=head, Commit_pc=PC, head+1 mod DEPTH, Count-1.
- Alloc: tail+1 mod DEPTH, Count+1. Alloc while Full is ignored; no pointer or count change.
- Alloc and retire in the same cycle: Count unchanged, both pointers advance.
- Head not ready (valid=0 or spec_valid=0): stall, all strobes 0, state held.
- Flush: head<=tail, Count<=0, FSM<=RUN, strobes 0 next cycle. Flush takes priority over retire and over Alloc in the same cycle, so that Alloc is dropped.
- HALT: no retirement until reset or Flush. Alloc is still counted.
- Pointers wrap 31->0 without special handling.

## Timing
- Reset values: head=0, tail=0, Count=0, FSM=RUN, Rd_Addr=0, Clr_entry=0, Clr_addr=0, Arch_we=0, Arch_waddr=0, Arch_wdata=0, Store_commit=0, Commit_pc=0, Full=0, Empty=1, Halted=0.
- Retire outputs (Clr_*, Arch_*, Store_commit, Commit_pc) are registered. They are high for exactly one cycle, in the cycle after the ready condition is sampled.
- Rd_Addr updates the cycle after a retire, so throughput is 1 retire/cycle with no double-retire of an entry.
- Full, Empty and Halted are registered from next-state values and track Count/FSM with zero extra lag.
- Reset mid-operation: in the next cycle all state is at reset values and any pending strobe is dropped.

## Test plan
- Reset: hold reset 2 cycles -> Empty=1, Full=0, Rd_Addr=0, all strobes 0.
- ALU retire: Alloc once; Data_out={32'hDEADBEEF, PC 32'h100, rd 5'd7, 2'b00, 1, 1} -> next cycle Arch_we=1, Arch_waddr=7, Arch_wdata=DEADBEEF, Clr_addr=0, Commit_pc=100; then Rd_Addr=1, Empty=1.
- Stall/ordering: head entry spec_valid=0 for 5 cycles while entry 1 is ready -> no strobes. Set spec_valid=1 -> entries 0 then 1 retire on consecutive cycles.
- Fill/wrap: 32 Allocs -> Full=1; 33rd Alloc ignored (Count stays 32). Retire all with type 10, with Alloc asserted during the last 8 retires -> Rd_Addr wraps 31->0, final Count=8.
- Store, halt and rd0: type 01 -> Store_commit=1 and Arch_we=0. Type 00 with rd=0 -> Clr_entry=1 and Arch_we=0. Type 11 -> Halted=1, with a following ready entry not retired until Flush.
- Flush with simultaneous Alloc and ready head -> no strobes next cycle, Count=0, Rd_Addr=tail, Halted=0.
